// File: rtl/init_llr_loader.sv
// Channel-LLR loader: saturates incoming soft samples and writes one ping-pong half
// of NUM_BANKS LLR RAM banks per frame, with occupancy tracking and abort on lock loss.
module init_llr_loader #(
    parameter int IN_W      = 12,
    parameter int DATA_W    = 11,
    parameter int ADDR_W    = 6,
    parameter int NUM_BANKS = 10
) (
    input  logic                     wrclk,
    input  logic                     reset,
    input  logic                     start_read,
    input  logic                     input_en,
    input  logic                     frame_lock,
    input  logic signed [IN_W-1:0]   data_in,
    input  logic                     buf_release,
    output logic [DATA_W-1:0]        data_Lch,
    output logic [ADDR_W-1:0]        wr_addr_Lch,
    output logic                     wr_addr_high_Lch,
    output logic [NUM_BANKS-1:0]     wren_Lch,
    output logic                     data_ready,
    output logic                     data_full,
    output logic                     frame_abort,
    output logic                     sat_flag
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic signed [IN_W-1:0] SAT_POS = IN_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_NEG = -SAT_POS;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, UNLOCK = 2'd2} state_t;

    state_t              state;
    logic [BANK_W-1:0]   bank;
    logic [ADDR_W-1:0]   cnt;
    logic [1:0]          occ, occ_nxt;
    logic [DATA_W-1:0]   sat_val;
    logic                sat_hit;
    logic                last_write, frame_done, rel;

    // Symmetric clamp so the most negative code never reaches the decoder.
    always_comb begin
        sat_val = data_in[DATA_W-1:0];
        sat_hit = 1'b0;
        if (data_in > SAT_POS) begin
            sat_val = SAT_POS[DATA_W-1:0];
            sat_hit = 1'b1;
        end else if (data_in < SAT_NEG) begin
            sat_val = SAT_NEG[DATA_W-1:0];
            sat_hit = 1'b1;
        end
    end

    assign last_write = (bank == BANK_W'(NUM_BANKS - 1)) && (cnt == '1);
    assign frame_done = (state == LOAD) && frame_lock && input_en && last_write;
    assign rel        = buf_release && (occ != 2'd0);

    always_comb begin
        occ_nxt = occ;
        if (frame_done && !rel)      occ_nxt = occ + 2'd1;
        else if (!frame_done && rel) occ_nxt = occ - 2'd1;
    end

    always_ff @(posedge wrclk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            bank             <= '0;
            cnt              <= '0;
            occ              <= '0;
            data_Lch         <= '0;
            wr_addr_Lch      <= '0;
            wr_addr_high_Lch <= 1'b1;
            wren_Lch         <= '0;
            data_ready       <= 1'b0;
            data_full        <= 1'b0;
            frame_abort      <= 1'b0;
            sat_flag         <= 1'b0;
        end else begin
            data_ready  <= 1'b0;
            frame_abort <= 1'b0;
            sat_flag    <= 1'b0;
            occ         <= occ_nxt;
            data_full   <= (occ_nxt == 2'd2);
            case (state)
                IDLE: begin
                    wren_Lch    <= '0;
                    wr_addr_Lch <= '0;
                    if (start_read && occ < 2'd2) begin
                        wr_addr_high_Lch <= ~wr_addr_high_Lch;
                        bank             <= '0;
                        cnt              <= '0;
                        state            <= LOAD;
                    end
                end
                LOAD: begin
                    if (!frame_lock) begin
                        wren_Lch    <= '0;
                        frame_abort <= 1'b1;
                        state       <= UNLOCK;
                    end else if (input_en) begin
                        data_Lch    <= sat_val;
                        sat_flag    <= sat_hit;
                        wren_Lch    <= NUM_BANKS'(1) << bank;
                        wr_addr_Lch <= cnt;
                        cnt         <= cnt + ADDR_W'(1);
                        if (cnt == '1) begin
                            if (last_write) begin
                                data_ready <= 1'b1;
                                bank       <= '0;
                                state      <= IDLE;
                            end else begin
                                bank <= bank + BANK_W'(1);
                            end
                        end
                    end else begin
                        wren_Lch <= '0;
                    end
                end
                // Partial half is dropped; a restart rewrites the same half.
                UNLOCK: begin
                    wren_Lch    <= '0;
                    wr_addr_Lch <= '0;
                    if (start_read && frame_lock) begin
                        bank  <= '0;
                        cnt   <= '0;
                        state <= LOAD;
                    end
                end
                default: begin
                    wren_Lch    <= '0;
                    wr_addr_Lch <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
